elink_trig_tx: RTL
==================

# elink_trig_tx

Transmit end of the triplicated trigger e-link. It accepts 12-bit trigger words over a valid/ready handshake and buffers them in a small FIFO. Each word is framed with a 2-bit header and serialized MSB-first onto three independent, redundantly registered e-link lanes. The downstream deserializers feed the trigger voter, which expects three identical 12-bit copies per frame. A per-frame fault-injection mask corrupts selected lanes so the voter's confidence path can be exercised in system.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of 2, at least 2.
- `IDLE_WORD`, 12'h000: payload sent in idle frames.
- `INJECT_XOR`, 12'hFFF: XOR pattern applied to the payload of injected lanes.
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 12: trigger word.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: the FIFO can accept a word (not full).
- `inject` in 3: per-lane corruption request, bit0 maps to `elink1`; sampled at frame load.
- `elink1`, `elink2`, `elink3` out 1 each: serial lanes.
- `frame_start` out 1: high while header bit 13 is on the lanes.
- `frames_sent` out 16: count of data frames loaded; wraps.

## Operation
- **Push**
  - A push occurs when `din_valid` and `din_ready` are both high at a posedge.
  - `din_ready` is `!full`, combinational from the FIFO occupancy register.
  - When the FIFO is full, input is stalled and no word is dropped.
- **Frame format**
  - A frame is 14 bits.
  - Data frame: {2'b10, word}.
  - Idle frame: {2'b01, IDLE_WORD}.
  - Bits are sent MSB first: header bit 13, header bit 12, then payload bits 11..0.
- **Bit counter**
  - `cnt` runs 0..13 and advances one per clock.
  - After 13 it returns to 0.
- **Load (at a posedge where `cnt`==0)**
  - If the FIFO is non-empty, pop its head and build a data frame. Otherwise build an idle frame.
  - Each lane has its own 14-bit shift register, loaded with the frame.
  - For each lane whose `inject` bit is 1, the payload is XORed with `INJECT_XOR`. The header is never corrupted.
  - `frames_sent` increments by 1 on a data-frame load only; 16'hFFFF wraps to 0.
- **Shift (at a posedge where `cnt`!=0)**
  - Each shift register shifts left by one and fills 0.
- **Outputs**
  - Each `elinkN` is the MSB of its lane's shift register.
  - The three shift registers are kept as separate registers with no shared logic between lanes, for SEU isolation.
- **FIFO pointers**
  - Read and write pointers are log2(DEPTH) bits with wrap-around.
  - Occupancy is a separate counter, 0..DEPTH.
  - A simultaneous push and pop leaves occupancy unchanged. This is allowed whenever the FIFO is not full before the edge.
  - When the FIFO is full, only a pop can occur at a load edge; the push is blocked by `din_ready`=0 during that cycle.
- **Reset (async assert)**
  - FIFO is emptied, `cnt`=0, shift registers are 0.
  - `elink1`/`elink2`/`elink3`=0, `frame_start`=0, `frames_sent`=0.
  - `din_ready`=1 as soon as `rst_n` is low; pushes only take effect after release.
  - Asserting reset mid-frame truncates the frame. The lanes drop to 0 immediately, and buffered words are discarded.
- **Frame boundaries**
  - The first posedge after reset release is a load edge.
  - Frames are back-to-back with no gaps: a load every 14 cycles.

## Timing
- **Load edge L:** `frame_start`=1 and lanes carry bit 13 during cycle L..L+1. Bit k is on the lanes during cycle L+(13-k).
- **`frame_start`:** registered; high for exactly 1 cycle per frame, every 14 cycles.
- **Push latency:**
  - A word pushed at edge P (FIFO empty, P not a load edge) is sent at the next load edge after P.
  - A push on the load edge itself is not bypassed. An idle frame goes out, and the word waits for the next load, 14 cycles later.
- **Throughput:** at most one word per 14 cycles. `din_ready` deasserts after DEPTH unconsumed pushes.
- **Inject timing:** `inject` affects only the frame loaded at the edge where it is sampled.

## Test plan
- **Reset:** hold `rst_n`=0 mid-stream. All lanes, `frame_start` and `frames_sent` go to 0 asynchronously. After release, the first frame is idle: lanes show 01 followed by twelve 0s, and `frame_start` is high on the first cycle.
- **Single word:** push 12'hABC 3 cycles after a load edge. At the next load, all three lanes show 10_1010_1011_1100, `frame_start` pulses, and `frames_sent`=1. The following frame is idle.
- **Overflow:** with DEPTH=4, hold `din_valid`=1 with words 1..6 starting on a non-load cycle. Check the following:
  - `din_ready` drops after 4 accepted pushes and reasserts for 1 cycle after each load pop.
  - All 6 words are sent in order and none is lost.
  - `frames_sent`=6.
- **Push on load edge:** push 12'h123 exactly at the load edge with the FIFO empty. That frame is idle; 12'h123 appears in the frame 14 cycles later.
- **Injection:** with `inject`=3'b010 at the load of 12'h5A5, `elink2` payload is 12'hA5A while `elink1`/`elink3` carry 12'h5A5, and all headers are 10. With 3'b111, all lanes carry 12'hA5A. The next frame is clean.
- **Counter wrap:** preload via a long run of 65536 data frames (or force). `frames_sent` goes 16'hFFFF -> 0; idle frames do not increment it.

Source files
------------

// File: rtl/elink_trig_tx.sv
// Triplicated trigger e-link transmitter: a word FIFO feeds three isolated
// 14-bit framing shift registers that are serialized MSB-first.

module elink_trig_lane #(
   parameter logic [11:0] IDLE_WORD  = 12'h000,
   parameter logic [11:0] INJECT_XOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        data_sel,
   input  logic [11:0] word,
   input  logic        inject,
   output logic        lane
);
   logic [13:0] sr;
   logic [1:0]  hdr;
   logic [11:0] payload;

   // Each lane builds its own frame so an upset in one lane cannot reach another.
   always_comb begin
      hdr     = data_sel ? 2'b10 : 2'b01;
      payload = data_sel ? word : IDLE_WORD;
      if (inject) payload = payload ^ INJECT_XOR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    sr <= '0;
      else if (load) sr <= {hdr, payload};
      else           sr <= {sr[12:0], 1'b0};
   end

   assign lane = sr[13];
endmodule

module elink_trig_tx #(
   parameter int          DEPTH      = 4,
   parameter logic [11:0] IDLE_WORD  = 12'h000,
   parameter logic [11:0] INJECT_XOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic [2:0]  inject,
   output logic        elink1,
   output logic        elink2,
   output logic        elink3,
   output logic        frame_start,
   output logic [15:0] frames_sent
);
   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [3:0]     LAST_BIT = 4'd13;

   logic [DEPTH-1:0][11:0] mem;
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [AW:0]            occ;
   logic [3:0]             cnt;
   logic [15:0]            frames_cnt;
   logic                   load, full, empty, push, pop;
   logic [2:0]             lanes;

   assign load      = (cnt == 4'd0);
   assign full      = (occ == OCC_FULL);
   assign empty     = (occ == '0);
   assign din_ready = !full;
   assign push      = din_valid && !full;
   assign pop       = load && !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Free-running bit counter; the frame boundary never waits for data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         frame_start <= 1'b0;
         frames_cnt  <= '0;
      end else begin
         cnt         <= (cnt == LAST_BIT) ? 4'd0 : cnt + 4'd1;
         frame_start <= load;
         if (pop) frames_cnt <= frames_cnt + 16'd1;
      end
   end

   assign frames_sent = frames_cnt;

   for (genvar g = 0; g < 3; g++) begin : g_lane
      elink_trig_lane #(
         .IDLE_WORD  (IDLE_WORD),
         .INJECT_XOR (INJECT_XOR)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load),
         .data_sel (!empty),
         .word     (mem[rd_ptr]),
         .inject   (inject[g]),
         .lane     (lanes[g])
      );
   end

   assign elink1 = lanes[0];
   assign elink2 = lanes[1];
   assign elink3 = lanes[2];
endmodule
